// File: rtl/penc_pkg.sv
// -----------------------------------------------------------------------------
// penc_pkg
// Shared types and defaults for the registered round-robin priority encoder.
//   penc_mode_e    : ordering selected by mode_i (fixed priority / round-robin)
//   PENC_N_DEFAULT : default request width
// -----------------------------------------------------------------------------
package penc_pkg;

  typedef enum logic {
    PENC_FIXED = 1'b0,
    PENC_RR    = 1'b1
  } penc_mode_e;

  localparam int PENC_N_DEFAULT = 16;

endpackage : penc_pkg

// File: rtl/prio_enc_n.sv
// -----------------------------------------------------------------------------
// prio_enc_n
// Combinational N-input priority encoder: reports the highest set index.
// Ports:
//   req_i   [N-1:0] : request vector, bit k requests index k
//   idx_o   [W-1:0] : highest set index (0 when nothing is set)
//   found_o         : at least one request bit is set
// -----------------------------------------------------------------------------
module prio_enc_n #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx_o   = req_i[k] ? W'(k) : idx_o;
      found_o = found_o | req_i[k];
    end
  end

endmodule : prio_enc_n

// File: rtl/rr_priority_encoder.sv
// -----------------------------------------------------------------------------
// rr_priority_encoder
// Registered N-to-W priority encoder with fixed-priority or round-robin
// ordering behind a valid/ready output register. One grant per cycle,
// one cycle latency.
//
// Build option:
//   RR_PENC_RR_EN : when defined, round-robin ordering and the last-accepted
//                   pointer are built and mode_i selects the ordering. When
//                   undefined the block is fixed priority only and mode_i is
//                   ignored; the port list is identical in both builds.
//
// Ports:
//   clk_i            : clock, rising edge
//   rst_ni           : asynchronous active-low reset
//   req_i    [N-1:0] : request vector, bit k requests index k
//   mode_i           : 0 = fixed priority, 1 = round-robin (sampled at load)
//   rdy_i            : downstream accepts the current output
//   vld_o            : output register holds a grant
//   idx_o    [W-1:0] : granted index
//   onehot_o [N-1:0] : one-hot copy of idx_o, all-zero when vld_o = 0
// -----------------------------------------------------------------------------
module rr_priority_encoder
  import penc_pkg::*;
#(
  parameter int N = PENC_N_DEFAULT,
  parameter int W = $clog2(N)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  input  logic         mode_i,
  input  logic         rdy_i,
  output logic         vld_o,
  output logic [W-1:0] idx_o,
  output logic [N-1:0] onehot_o
);

  logic         vld_q, vld_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] onehot_q, onehot_d;

  logic         ld_s;
  logic [W-1:0] full_idx_s;
  logic         full_found_s;
  logic [W-1:0] win_idx_s;

  // The output register reloads whenever it is empty or being drained.
  assign ld_s = !vld_q || rdy_i;

  // Unmasked search: the fixed-priority result and the round-robin fallback.
  prio_enc_n #(.N(N), .W(W)) u_full (
    .req_i   (req_i),
    .idx_o   (full_idx_s),
    .found_o (full_found_s)
  );

`ifdef RR_PENC_RR_EN
  logic         acc_s;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] base_s;
  logic [N-1:0] low_req_s;
  logic [W-1:0] low_idx_s;
  logic         low_found_s;
  penc_mode_e   mode_s;

  assign acc_s  = vld_q && rdy_i;
  assign mode_s = penc_mode_e'(mode_i);
  // Using the index being accepted right now keeps that requester from
  // winning the same-edge reload while others are waiting.
  assign base_s = acc_s ? idx_q : ptr_q;

  // Keep only requests strictly below base; they are searched first so the
  // order is base-1 down to 0, then wraps to N-1 down to base.
  always_comb begin
    low_req_s = '0;
    for (int k = 0; k < N; k++) begin
      low_req_s[k] = req_i[k] && (W'(k) < base_s);
    end
  end

  prio_enc_n #(.N(N), .W(W)) u_low (
    .req_i   (low_req_s),
    .idx_o   (low_idx_s),
    .found_o (low_found_s)
  );

  // Winner selection: masked result in round-robin mode, else unmasked.
  always_comb begin
    win_idx_s = full_idx_s;
    if ((mode_s == PENC_RR) && low_found_s) begin
      win_idx_s = low_idx_s;
    end else begin
      win_idx_s = full_idx_s;
    end
  end

  // Pointer next state: remembers the last accepted index in either mode.
  always_comb begin
    ptr_d = ptr_q;
    if (acc_s) begin
      ptr_d = idx_q;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Last-accepted pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_mode_s;

  assign unused_mode_s = mode_i;
  assign win_idx_s     = full_idx_s;
`endif

  // Output register next state: load the winner on ld, otherwise hold.
  always_comb begin
    vld_d    = vld_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    if (ld_s) begin
      vld_d = full_found_s;
      idx_d = full_found_s ? win_idx_s : '0;
      for (int k = 0; k < N; k++) begin
        onehot_d[k] = full_found_s && (win_idx_s == W'(k));
      end
    end else begin
      vld_d    = vld_q;
      idx_d    = idx_q;
      onehot_d = onehot_q;
    end
  end

  // Output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q    <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
    end else begin
      vld_q    <= vld_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
    end
  end

  assign vld_o    = vld_q;
  assign idx_o    = idx_q;
  assign onehot_o = onehot_q;

endmodule : rr_priority_encoder

// File: tb/tb_rr_priority_encoder.sv
// -----------------------------------------------------------------------------
// tb_rr_priority_encoder
// Directed self-checking bench for rr_priority_encoder (N = 16). Expected
// values are hand-computed; where round-robin and fixed-priority builds
// differ, the RR_PENC_RR_EN macro selects the expected value.
// -----------------------------------------------------------------------------
module tb_rr_priority_encoder;

  localparam int N = 16;
  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         mode;
  logic         rdy;
  logic         vld;
  logic [W-1:0] idx;
  logic [N-1:0] onehot;

  int n_tests;
  int n_fail;

  rr_priority_encoder #(.N(N)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req),
    .mode_i   (mode),
    .rdy_i    (rdy),
    .vld_o    (vld),
    .idx_o    (idx),
    .onehot_o (onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle past the edge before checking.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the full output triple for a valid grant of index e.
  task automatic check_grant(input string tag, input int e);
    logic [N-1:0] oh;
    oh    = '0;
    oh[e] = 1'b1;
    check_eq({tag, ".vld"},    32'(vld),    32'd1);
    check_eq({tag, ".idx"},    32'(idx),    32'(e));
    check_eq({tag, ".onehot"}, 32'(onehot), 32'(oh));
  endtask

  task automatic check_empty(input string tag);
    check_eq({tag, ".vld"},    32'(vld),    32'd0);
    check_eq({tag, ".idx"},    32'(idx),    32'd0);
    check_eq({tag, ".onehot"}, 32'(onehot), 32'd0);
  endtask

`ifdef RR_PENC_RR_EN
  int rr_seq[5] = '{15, 10, 5, 0, 15};
  localparam int EXP_T5B = 0;
`else
  int rr_seq[5] = '{15, 15, 15, 15, 15};
  localparam int EXP_T5B = 5;
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    req     = 16'h0000;
    mode    = 1'b0;
    rdy     = 1'b0;

    // Reset state.
    tick();
    tick();
    check_empty("reset");
    rst_n = 1'b1;

    // Test 1: no request after reset.
    rdy = 1'b1;
    tick();
    check_empty("t1_idle");

    // Test 2: fixed priority, back-to-back.
    mode = 1'b0;
    req  = 16'h8421;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_grant($sformatf("t2_fixed%0d", i), 15);
    end

    // Test 3: round-robin rotation from a fresh pointer.
    rst_n = 1'b0;
    #1;
    check_empty("t3_rst");
    rst_n = 1'b1;
    mode  = 1'b1;
    req   = 16'h8421;
    rdy   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_grant($sformatf("t3_rr%0d", i), rr_seq[i]);
    end

    // Test 4: load 5, then stall four cycles while req changes.
    req = 16'h0030;
    tick();
    check_grant("t4_load", 5);
    rdy = 1'b0;
    req = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_grant($sformatf("t4_stall%0d", i), 5);
    end

    // Test 5: single request wins; then wrap below the accepted index.
    rdy = 1'b1;
    req = 16'h0020;
    tick();
    check_grant("t5_single", 5);
    req = 16'h0021;
    tick();
    check_grant("t5_wrap", EXP_T5B);

    // Accept with empty request vector drops valid.
    req = 16'h0000;
    tick();
    check_empty("acc_empty");

    // Test 6: async reset mid-stall, then RR restart.
    req = 16'h0003;
    tick();
    check_grant("t6_load", 1);
    rdy = 1'b0;
    tick();
    check_grant("t6_stall", 1);
    rst_n = 1'b0;
    #1;
    check_empty("t6_async_rst");
    tick();
    rst_n = 1'b1;
    mode  = 1'b1;
    req   = 16'h0003;
    rdy   = 1'b1;
    tick();
    check_grant("t6_after", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_rr_priority_encoder

// File: doc/rr_priority_encoder.md
# rr_priority_encoder

Parametrised, registered successor to the fixed 16-to-4 priority encoder in the pipeline. It reduces an N-bit request vector to a binary index plus one-hot grant, with selectable fixed-priority or round-robin ordering. The result sits in an output register behind a valid/ready handshake, so downstream stages (hazard/forwarding selection, writeback arbitration) can stall it. Throughput is one grant per cycle; latency is one cycle.

## Interface
- `N`, default 16: request width, ≥2, not required to be a power of two.
- `W`, default `$clog2(N)`: index width, derived; never overridden.
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `req_i` in N: request vector; bit k requests index k.
- `mode_i` in 1: 0 = fixed priority, 1 = round-robin; sampled at load.
- `rdy_i` in 1: downstream accepts the current output.
- `vld_o` out 1: output register holds a grant.
- `idx_o` out W: granted index.
- `onehot_o` out N: one-hot copy of `idx_o`; all-zero when `vld_o`=0.

## Operation
- Fixed priority: the highest set index wins, matching the legacy encoder ordering.
- Round-robin: the search starts at `(base-1) mod N` and descends, wrapping from 0 to N-1. It ends at `base`, which has the lowest priority.
- `ptr_q` (W bits) holds the last accepted index.
- `base` is `idx_o` when an accept occurs this cycle, otherwise `ptr_q`. A requester just accepted therefore never wins the same-edge reload while another request is pending.
- The load enable is `ld = !vld_o || rdy_i`.
- On `ld`:
  - `vld_o <= |req_i`;
  - `idx_o` and `onehot_o` take the winner, or 0 and all-zero if there is no request.
- Without `ld`, the output holds stable and `req_i` is ignored. Requests are not latched, so a request that drops while the output is stalled is lost.
- Accept means `vld_o && rdy_i`. On accept, `ptr_q <= idx_o`. `ptr_q` is updated only on accept, in both modes.
- A change of `mode_i` takes effect at the next load. `ptr_q` is preserved across mode changes.

## Timing
- Reset (asynchronous assert, synchronous-safe release): `vld_o`=0, `idx_o`=0, `onehot_o`=0, `ptr_q`=0.
  - With `ptr_q`=0, the first round-robin search starts at N-1, identical to fixed priority.
- Latency: a request sampled at edge t with `ld`=1 appears on the outputs after edge t.
- Back-to-back: with `rdy_i` held at 1, a new grant issues every cycle.
- Stall: with `vld_o`=1 and `rdy_i`=0, all outputs hold bit-exact for as many cycles as the stall lasts.
- Accept with an empty `req_i`: `vld_o` falls on the next edge, `idx_o` goes to 0, and `ptr_q` still updates.
- Reset asserted mid-stall: outputs clear immediately and the pending grant is discarded.
- Only one request set: it wins regardless of mode or `ptr_q`.

## Configuration
- `RR_PENC_RR_EN` defined: round-robin logic and `ptr_q` are compiled in, and `mode_i` behaves as above.
- `RR_PENC_RR_EN` undefined:
  - the block is fixed priority only;
  - `mode_i` is ignored;
  - `ptr_q` is not built;
  - ports are unchanged.

## Structure
- Package `penc_pkg` holds:
  - `penc_mode_e` (`PENC_FIXED`=1'b0, `PENC_RR`=1'b1);
  - `PENC_N_DEFAULT`=16.
- Sub-module `prio_enc_n`: combinational, parametrised by N, outputs the highest-set index plus a `found` flag.
- Round-robin uses two instances of `prio_enc_n`:
  - one on `req_i` masked to indices below `base`;
  - one on unmasked `req_i`, used when the masked result is empty.

## Test plan
1. Reset, then `req_i`=16'h0000 -> `vld_o`=0, `idx_o`=0, `onehot_o`=0.
2. `mode_i`=0, `req_i`=16'h8421, `rdy_i`=1 for 3 cycles -> `idx_o`=15 every cycle.
3. `mode_i`=1, `req_i`=16'h8421 held, `rdy_i`=1 -> grants in order 15, 10, 5, 0, 15.
4. `req_i`=16'h0030, `rdy_i`=0 for 4 cycles, then 1 -> `idx_o`=5 and `onehot_o`=16'h0020 are held stable for all 4 stalled cycles; one accept follows.
5. Round-robin with `ptr_q`=5, `req_i`=16'h0020 only -> `idx_o`=5. Then `req_i`=16'h0021 -> `idx_o`=0.
6. Assert `rst_ni`=0 while `vld_o`=1 and stalled -> outputs clear within the same cycle. After release, `req_i`=16'h0003 in round-robin mode -> `idx_o`=1.
7. Build without `RR_PENC_RR_EN`, `mode_i`=1, `req_i`=16'h8421 -> `idx_o`=15 every cycle.
